mem_cache_ctrl: RTL and testbench

MEM_CACHE_CTRL -- requirements
Module: mem_cache_ctrl

---
 rtl/mem_cache_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_cache_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cache_ctrl.sv
// Direct-mapped, one-word-per-line write-through data cache with no write-allocate.
// Misses and all stores freeze the pipeline until the data memory answers, then pass through DONE.
module mem_cache_ctrl #(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic        cache_en,
  input  logic        is_LB_SB,
  input  logic [31:0] alu_result,
  input  logic [31:0] rt_data,
  output logic [31:0] rd_data,
  output logic        freeze,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ready
);

  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;

  state_e             state_q, state_d;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES];
  logic [31:0]        hold_q;

  logic [1:0]         offset;
  logic [IDX_W-1:0]   index;
  logic [TAG_W-1:0]   tag;
  logic               access, is_store, is_load, hit;
  logic               fill_en, merge_en;
  logic [31:0]        word_addr, wdata_w;
  logic [3:0]         be_w;

  assign offset    = alu_result[1:0];
  assign index     = alu_result[IDX_W+1:2];
  assign tag       = alu_result[31:IDX_W+2];
  assign access    = cache_en & (mem_to_reg | mem_write);
  assign is_store  = mem_write;
  assign is_load   = mem_to_reg & ~mem_write;
  assign hit       = valid_q[index] & (tag_q[index] == tag);
  assign word_addr = {alu_result[31:2], 2'b00};
  assign be_w      = is_LB_SB ? (4'b0001 << offset) : 4'b1111;
  assign wdata_w   = is_LB_SB ? {4{rt_data[7:0]}} : rt_data;

  function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] off,
                                           input logic byte_op);
    logic [7:0] b;
    unique case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return byte_op ? {{24{b[7]}}, b} : word;
  endfunction

  always_comb begin
    state_d  = state_q;
    freeze   = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    dm_be    = '0;
    rd_data  = '0;
    fill_en  = 1'b0;
    merge_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (is_store) begin
            freeze  = 1'b1;
            state_d = StWrite;
          end else if (hit) begin
            rd_data = load_fmt(data_q[index], offset, is_LB_SB);
          end else begin
            freeze  = 1'b1;
            state_d = StFill;
          end
        end
      end
      StFill: begin
        freeze  = 1'b1;
        dm_req  = 1'b1;
        dm_addr = word_addr;
        if (dm_ready) begin
          fill_en = 1'b1;
          state_d = StDone;
        end
      end
      StWrite: begin
        freeze   = 1'b1;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = word_addr;
        dm_wdata = wdata_w;
        dm_be    = be_w;
        if (dm_ready) begin
          merge_en = hit;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (is_load) rd_data = load_fmt(hold_q, offset, is_LB_SB);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Outputs must drop the moment reset asserts, not at the next edge.
    if (!rst_b) begin
      state_d  = StIdle;
      freeze   = 1'b0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_be    = '0;
      rd_data  = '0;
      fill_en  = 1'b0;
      merge_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      valid_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en) begin
        valid_q[index] <= 1'b1;
        hold_q         <= dm_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[index]  <= tag;
      data_q[index] <= dm_rdata;
    end else if (merge_en) begin
      for (int i = 0; i < 4; i++) begin
        if (dm_be[i]) data_q[index][8*i +: 8] <= dm_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Directed bench for mem_cache_ctrl: fills, hits, byte/word stores, write-through miss, reset abort.
module tb_mem_cache_ctrl;

  logic        clk, rst_b;
  logic        mem_write, mem_to_reg, cache_en, is_LB_SB;
  logic [31:0] alu_result, rt_data, rd_data;
  logic        freeze, dm_req, dm_we, dm_ready;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;

  int checks = 0;
  int failures = 0;
  int frz;
  logic [31:0] cap_addr, cap_wdata, first_addr, first_wdata;
  logic [3:0]  cap_be, first_be;
  logic        cap_we;

  mem_cache_ctrl #(.LINES(16), .IDX_W(4)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .cache_en   (cache_en),
    .is_LB_SB   (is_LB_SB),
    .alu_result (alu_result),
    .rt_data    (rt_data),
    .rd_data    (rd_data),
    .freeze     (freeze),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_be      (dm_be),
    .dm_rdata   (dm_rdata),
    .dm_ready   (dm_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 2 units after it.
  task automatic drive(input logic cen, mtr, mw, lbsb, input logic [31:0] addr, rt);
    cache_en   = cen;
    mem_to_reg = mtr;
    mem_write  = mw;
    is_LB_SB   = lbsb;
    alu_result = addr;
    rt_data    = rt;
    #1;
  endtask

  // Memory model: answers on the lat-th cycle of dm_req. Returns sitting in DONE.
  task automatic run_mem(input int lat, input logic [31:0] rdata);
    int  req_n;
    bit  done;
    req_n = 0;
    done  = 0;
    frz   = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (!freeze) begin
        done = 1;
      end else begin
        frz++;
        if (dm_req) begin
          req_n++;
          if (req_n == 1) begin
            first_addr  = dm_addr;
            first_be    = dm_be;
            first_wdata = dm_wdata;
          end
          if (req_n == lat) begin
            dm_ready  = 1'b1;
            dm_rdata  = rdata;
            cap_addr  = dm_addr;
            cap_be    = dm_be;
            cap_wdata = dm_wdata;
            cap_we    = dm_we;
          end
        end
        @(posedge clk);
        #1;
        dm_ready = 1'b0;
        dm_rdata = '0;
        #1;
      end
    end
    if (!done) check("mem_timeout", 32'd1, 32'd0);
  endtask

  task automatic next_idle();
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst_b    = 1'b0;
    dm_ready = 1'b0;
    dm_rdata = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #11;
    check("rst_freeze", {31'b0, freeze}, 32'd0);
    check("rst_dm_req", {31'b0, dm_req}, 32'd0);
    check("rst_dm_we", {31'b0, dm_we}, 32'd0);
    check("rst_dm_be", {28'b0, dm_be}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;

    // Cold load 0x40, 3-cycle memory
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    check("cold_freeze_comb", {31'b0, freeze}, 32'd1);
    check("cold_no_req_idle", {31'b0, dm_req}, 32'd0);
    run_mem(3, 32'hDEADBEEF);
    check("cold_freeze_cycles", frz, 32'd4);
    check("cold_addr", cap_addr, 32'h40);
    check("cold_we", {31'b0, cap_we}, 32'd0);
    check("cold_done_rd", rd_data, 32'hDEADBEEF);
    check("cold_done_req", {31'b0, dm_req}, 32'd0);
    check("cold_done_freeze", {31'b0, freeze}, 32'd0);
    next_idle();

    // Repeat load hits, plus byte loads of the same line
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    check("hit_freeze", {31'b0, freeze}, 32'd0);
    check("hit_req", {31'b0, dm_req}, 32'd0);
    check("hit_rd", rd_data, 32'hDEADBEEF);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h41, 32'h0);
    check("lb_off1", rd_data, 32'hFFFFFFBE);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h42, 32'h0);
    check("lb_off2", rd_data, 32'hFFFFFFAD);
    next_idle();

    // SB 0x80 to 0x43 (hit), upper rt bits must not leak
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h43, 32'h12345680);
    check("sb_freeze_comb", {31'b0, freeze}, 32'd1);
    run_mem(2, 32'h0);
    check("sb_freeze_cycles", frz, 32'd3);
    check("sb_be", {28'b0, cap_be}, 32'h8);
    check("sb_wdata", cap_wdata, 32'h80808080);
    check("sb_addr", cap_addr, 32'h40);
    check("sb_we", {31'b0, cap_we}, 32'd1);
    check("sb_stable_addr", cap_addr, first_addr);
    check("sb_stable_wdata", cap_wdata, first_wdata);
    check("sb_done_freeze", {31'b0, freeze}, 32'd0);
    next_idle();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h43, 32'h0);
    check("lb_after_sb_freeze", {31'b0, freeze}, 32'd0);
    check("lb_after_sb", rd_data, 32'hFFFFFF80);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    check("lw_after_sb", rd_data, 32'h80ADBEEF);
    next_idle();

    // Store miss to 0x400: write-through only
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h400, 32'h11223344);
    run_mem(1, 32'h0);
    check("sw_miss_be", {28'b0, cap_be}, 32'hF);
    check("sw_miss_wdata", cap_wdata, 32'h11223344);
    check("sw_miss_addr", cap_addr, 32'h400);
    next_idle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    check("keep_tag_freeze", {31'b0, freeze}, 32'd0);
    check("keep_tag_rd", rd_data, 32'h80ADBEEF);
    next_idle();

    // Fill line 1, then word store hit into it
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
    run_mem(1, 32'h12345678);
    check("fill1_cycles", frz, 32'd2);
    check("fill1_done_rd", rd_data, 32'h12345678);
    next_idle();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h104, 32'h0);
    check("lb_pos", rd_data, 32'h00000078);
    next_idle();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 32'hCAFEF00D);
    run_mem(1, 32'h0);
    next_idle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
    check("sw_hit_lw", rd_data, 32'hCAFEF00D);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h105, 32'h0);
    check("sw_hit_lb", rd_data, 32'hFFFFFFF0);
    next_idle();

    // LB miss: byte selected from the hold register in DONE
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h20B, 32'h0);
    run_mem(2, 32'h7F00A5C3);
    check("lb_miss_addr", cap_addr, 32'h208);
    check("lb_miss_done_rd", rd_data, 32'h0000007F);
    next_idle();

    // Reset during FILL
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0);
    @(posedge clk); #2;
    check("abort_in_fill_req", {31'b0, dm_req}, 32'd1);
    rst_b = 1'b0;
    #1;
    check("abort_freeze", {31'b0, freeze}, 32'd0);
    check("abort_req", {31'b0, dm_req}, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_b = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    check("post_rst_miss", {31'b0, freeze}, 32'd1);
    run_mem(1, 32'h55AA55AA);
    check("post_rst_done_rd", rd_data, 32'h55AA55AA);
    next_idle();

    // cache_en low: no access at all
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    check("noen_freeze", {31'b0, freeze}, 32'd0);
    check("noen_req", {31'b0, dm_req}, 32'd0);
    check("noen_rd", rd_data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
